// File: rtl/bsg_burst_sink_pkg.sv
// Shared types and constants for the locking-arbiter burst sink.
// Holds the FSM state enum and the position of the header length field.
// Imported by bsg_burst_sink_buf and bsg_locking_arb_burst_sink.
package bsg_burst_sink_pkg;

  // HDR: the next accepted beat is a header. BODY: body beats remain.
  typedef enum logic [0:0] {
    e_hdr  = 1'b0,
    e_body = 1'b1
  } state_e;

  // The length field sits at the bottom of the header beat.
  localparam int len_lsb_gp = 0;

  function automatic int len_msb(input int len_width);
    return len_lsb_gp + len_width - 1;
  endfunction

endpackage

// File: rtl/bsg_burst_sink_buf.sv
// Two-entry FIFO holding {last, src, data} beats for the burst sink.
// Latency: a written entry is visible on v_o/data_o one cycle later.
// Backpressure: ready_o is low when both entries are full (registered count only).
//
// Ports:
//   clk_i, reset_n_i      clock, async active-low reset (clears occupancy)
//   v_i, data_i           write strobe and entry; ignored while full
//   ready_o               not full; no combinational path from v_i or yumi_i
//   v_o, data_o, yumi_i   head entry valid, head entry, consumer pop
module bsg_burst_sink_buf #(
  parameter int width_p = 37
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  logic [width_p-1:0] mem_r [2];
  logic               wr_ptr_r;
  logic               rd_ptr_r;
  logic [1:0]         count_r;
  logic               push;
  logic               pop;

  assign ready_o = (count_r != 2'd2);
  assign v_o     = (count_r != 2'd0);
  assign data_o  = mem_r[rd_ptr_r];

  // Writes to a full buffer and pops of an empty one are dropped so the
  // occupancy can never wrap.
  assign push = v_i & ready_o;
  assign pop  = yumi_i & v_o;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push) wr_ptr_r <= ~wr_ptr_r;
      if (pop)  rd_ptr_r <= ~rd_ptr_r;
      case ({push, pop})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push) mem_r[wr_ptr_r] <= data_i;
  end

endmodule

// File: rtl/bsg_locking_arb_burst_sink.sv
// Burst sink behind a locking fixed-priority arbiter: parses headers, counts body beats, unlocks on the last.
// Latency: accepted beat on v_o after 1 cycle; unlock_o is combinational with the last accept.
// Backpressure: ready_o = buffer not full (registered), forced low with unlock_o high during reset.
//
// Ports:
//   clk_i, reset_n_i           clock, async active-low reset
//   grants_i, data_i           one-hot grant (any bit = beat this cycle) and muxed beat
//   ready_o, unlock_o          to arbiter ready_i / unlock_i
//   v_o, data_o, src_o, last_o head beat with its requester index and end-of-burst flag
//   yumi_i                     consumer takes the head beat
//   error_o                    sticky protocol error
module bsg_locking_arb_burst_sink
  import bsg_burst_sink_pkg::*;
#(
  parameter int inputs_p    = 16,
  parameter int width_p     = 32,
  parameter int len_width_p = 8,
  localparam int lg_inputs_lp = $clog2(inputs_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [inputs_p-1:0]     grants_i,
  input  logic [width_p-1:0]      data_i,
  output logic                    ready_o,
  output logic                    unlock_o,
  output logic                    v_o,
  output logic [width_p-1:0]      data_o,
  output logic [lg_inputs_lp-1:0] src_o,
  output logic                    last_o,
  input  logic                    yumi_i,
  output logic                    error_o
);

  localparam int len_msb_lp = len_msb(len_width_p);
  localparam int entry_w_lp = 1 + lg_inputs_lp + width_p;

  state_e                  state_r, state_n;
  logic [len_width_p-1:0]  cnt_r, cnt_n;
  logic [lg_inputs_lp-1:0] src_r, src_n;
  logic                    error_r, error_n;

  logic                    acc;
  logic                    last;
  logic                    grants_onehot;
  logic [lg_inputs_lp-1:0] grant_idx;
  logic [len_width_p-1:0]  hdr_len;
  logic                    buf_ready;
  logic [entry_w_lp-1:0]   buf_data;

  assign acc     = |grants_i;
  assign hdr_len = data_i[len_msb_lp:len_lsb_gp];

  // Zero is treated as one-hot here; acc gates every use of this flag.
  assign grants_onehot = ((grants_i & (grants_i - inputs_p'(1))) == '0);

  // Lowest set bit wins, so an illegal multi-bit grant still yields a
  // definite index for the buffered beat.
  always_comb begin
    grant_idx = '0;
    for (int i = inputs_p - 1; i >= 0; i--) begin
      if (grants_i[i]) grant_idx = lg_inputs_lp'(i);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= e_hdr;
      cnt_r   <= '0;
      src_r   <= '0;
      error_r <= 1'b0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      src_r   <= src_n;
      error_r <= error_n;
    end
  end

  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    src_n   = src_r;
    last    = 1'b0;
    case (state_r)
      e_hdr: begin
        if (acc) begin
          src_n = grant_idx;
          if (hdr_len == '0) begin
            // Header with no body: it is its own last beat.
            last = 1'b1;
          end else begin
            cnt_n   = hdr_len;
            state_n = e_body;
          end
        end
      end
      e_body: begin
        if (acc) begin
          cnt_n = cnt_r - len_width_p'(1);
          if (cnt_r == len_width_p'(1)) begin
            last    = 1'b1;
            state_n = e_hdr;
          end
        end
      end
      default: state_n = e_hdr;
    endcase
  end

  always_comb begin
    error_n = error_r;
    if (acc && !grants_onehot)                       error_n = 1'b1;
    if (acc && (state_r == e_body) && (grant_idx != src_r)) error_n = 1'b1;
    if (yumi_i && !v_o)                              error_n = 1'b1;
  end

  assign error_o = error_r;

  // Reset releases any lock the arbiter holds, even mid-burst, and blocks
  // new grants until the sink is out of reset.
  assign unlock_o = ~reset_n_i | (acc & last);
  assign ready_o  = reset_n_i & buf_ready;

  bsg_burst_sink_buf #(
    .width_p (entry_w_lp)
  ) u_buf (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (acc),
    .data_i    ({last, grant_idx, data_i}),
    .ready_o   (buf_ready),
    .v_o       (v_o),
    .data_o    (buf_data),
    .yumi_i    (yumi_i)
  );

  assign last_o = buf_data[entry_w_lp-1];
  assign src_o  = buf_data[width_p +: lg_inputs_lp];
  assign data_o = buf_data[width_p-1:0];

endmodule

// File: tb/tb_bsg_locking_arb_burst_sink.sv
module tb_bsg_locking_arb_burst_sink;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] grants = '0;
  logic [31:0] data = '0;
  logic        ready, unlock, v, last, yumi, error;
  logic [31:0] data_out;
  logic [3:0]  src;
  logic        yumi_en = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Consumer takes the head whenever it is enabled and something is there.
  assign yumi = yumi_en & v;

  bsg_locking_arb_burst_sink #(
    .inputs_p    (16),
    .width_p     (32),
    .len_width_p (8)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .grants_i  (grants),
    .data_i    (data),
    .ready_o   (ready),
    .unlock_o  (unlock),
    .v_o       (v),
    .data_o    (data_out),
    .src_o     (src),
    .last_o    (last),
    .yumi_i    (yumi),
    .error_o   (error)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        last;
    logic [3:0]  src;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];
  int   remaining = 0;   // body beats still owed by the current burst
  int   burst_src = 0;
  bit   m_err = 0;

  function automatic int lowest_idx(input logic [15:0] g);
    for (int i = 0; i < 16; i++) if (g[i]) return i;
    return 0;
  endfunction

  function automatic bit is_onehot(input logic [15:0] g);
    int n = 0;
    for (int i = 0; i < 16; i++) if (g[i]) n++;
    return n == 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int   sz;
    int   enc;
    bit   lst;
    ent_t e;
    if (!rst_n) begin
      q.delete();
      remaining = 0;
      m_err = 0;
    end else begin
      sz = q.size();
      if (yumi) begin
        if (sz > 0) void'(q.pop_front());
        else m_err = 1;
      end
      if (grants != 0) begin
        enc = lowest_idx(grants);
        if (!is_onehot(grants)) m_err = 1;
        if (remaining == 0) begin
          burst_src = enc;
          remaining = int'(data[7:0]);
          lst = (remaining == 0);
        end else begin
          if (enc != burst_src) m_err = 1;
          remaining = remaining - 1;
          lst = (remaining == 0);
        end
        e.last = lst;
        e.src  = enc[3:0];
        e.data = data;
        if (sz < 2) q.push_back(e);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : compare
    bit exp_unlock;
    if (!rst_n) begin
      chk("rst_unlock", 64'(unlock), 64'd1);
      chk("rst_ready", 64'(ready), 64'd0);
      chk("rst_v", 64'(v), 64'd0);
      chk("rst_error", 64'(error), 64'd0);
    end else begin
      exp_unlock = (grants != 0) &&
                   ((remaining == 0) ? (data[7:0] == 8'd0) : (remaining == 1));
      chk("unlock", 64'(unlock), 64'(exp_unlock));
      chk("ready", 64'(ready), 64'(q.size() < 2));
      chk("v", 64'(v), 64'(q.size() != 0));
      chk("error", 64'(error), 64'(m_err));
      if (q.size() != 0) begin
        chk("data_o", 64'(data_out), 64'(q[0].data));
        chk("src_o", 64'(src), 64'(q[0].src));
        chk("last_o", 64'(last), 64'(q[0].last));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input logic [15:0] g, input logic [31:0] d);
    @(posedge clk);
    #1;
    grants = g;
    data   = d;
  endtask

  initial begin
    // reset values
    #3;
    chk("lit_rst_unlock", 64'(unlock), 64'd1);
    chk("lit_rst_ready", 64'(ready), 64'd0);
    cyc(16'h0, 32'h0);
    rst_n = 1'b1;
    #3;
    chk("lit_ready_after_rst", 64'(ready), 64'd1);

    // single burst: len=3 from requester 2
    yumi_en = 1'b1;
    cyc(16'h0004, 32'hAB00_0003);
    #3 chk("lit_hdr_no_unlock", 64'(unlock), 64'd0);
    cyc(16'h0004, 32'h0000_0011);
    #3 chk("lit_hdr_out_src", 64'(src), 64'd2);
    cyc(16'h0004, 32'h0000_0022);
    cyc(16'h0004, 32'h0000_0033);
    #3 chk("lit_unlock_4th", 64'(unlock), 64'd1);
    cyc(16'h0, 32'h0);
    #3 chk("lit_last_4th", 64'(last), 64'd1);
    chk("lit_data_4th", 64'(data_out), 64'h33);

    // zero-length burst from requester 15, then another header
    cyc(16'h8000, 32'hCAFE_0000);
    #3 chk("lit_zero_unlock", 64'(unlock), 64'd1);
    cyc(16'h0001, 32'h0000_0100);
    #3 chk("lit_zero_src", 64'(src), 64'd15);
    chk("lit_zero_last", 64'(last), 64'd1);
    chk("lit_still_hdr", 64'(unlock), 64'd1);
    cyc(16'h0, 32'h0);
    cyc(16'h0, 32'h0);

    // backpressure: two beats held, then one pop
    yumi_en = 1'b0;
    cyc(16'h0002, 32'h0000_0002);
    cyc(16'h0002, 32'h0000_00B1);
    cyc(16'h0, 32'h0);
    #3 chk("lit_bp_ready", 64'(ready), 64'd0);
    chk("lit_bp_head", 64'(data_out), 64'h2);
    cyc(16'h0, 32'h0);
    yumi_en = 1'b1;
    cyc(16'h0, 32'h0);
    yumi_en = 1'b0;
    #3 chk("lit_bp_ready_again", 64'(ready), 64'd1);
    chk("lit_bp_order", 64'(data_out), 64'hB1);
    cyc(16'h0002, 32'h0000_00B2);
    yumi_en = 1'b1;
    #3 chk("lit_bp_unlock", 64'(unlock), 64'd1);
    cyc(16'h0, 32'h0);
    cyc(16'h0, 32'h0);
    cyc(16'h0, 32'h0);

    // back-to-back bursts: src 3 then src 5 right after the unlock
    cyc(16'h0008, 32'h0000_0001);
    cyc(16'h0008, 32'h0000_00D1);
    cyc(16'h0020, 32'h0000_0001);
    #3 chk("lit_b2b_src3", 64'(src), 64'd3);
    cyc(16'h0020, 32'h0000_00D2);
    cyc(16'h0, 32'h0);
    #3 chk("lit_b2b_src5", 64'(src), 64'd5);
    chk("lit_b2b_noerr", 64'(error), 64'd0);
    cyc(16'h0, 32'h0);

    // protocol error: source switches mid-burst, then a non-one-hot grant
    cyc(16'h0040, 32'h0000_0002);
    cyc(16'h0040, 32'h0000_00E1);
    cyc(16'h0080, 32'h0000_00E2);
    cyc(16'h0, 32'h0);
    #3 chk("lit_err_set", 64'(error), 64'd1);
    chk("lit_err_src", 64'(src), 64'd7);
    cyc(16'h0003, 32'h0000_0000);
    cyc(16'h0, 32'h0);
    #3 chk("lit_err_sticky", 64'(error), 64'd1);
    cyc(16'h0, 32'h0);

    // reset mid-burst: 2 of 5 body beats, then reset
    cyc(16'h0001, 32'h0000_0005);
    cyc(16'h0001, 32'h0000_00F1);
    cyc(16'h0001, 32'h0000_00F2);
    @(posedge clk);
    #1;
    rst_n  = 1'b0;
    grants = '0;
    #3 chk("lit_mid_rst_unlock", 64'(unlock), 64'd1);
    chk("lit_mid_rst_ready", 64'(ready), 64'd0);
    chk("lit_mid_rst_err", 64'(error), 64'd0);
    cyc(16'h0, 32'h0);
    rst_n = 1'b1;
    #3 chk("lit_post_rst_v", 64'(v), 64'd0);
    chk("lit_post_rst_ready", 64'(ready), 64'd1);
    cyc(16'h0002, 32'h0000_0000);
    #3 chk("lit_post_rst_hdr", 64'(unlock), 64'd1);
    cyc(16'h0, 32'h0);
    cyc(16'h0, 32'h0);
    cyc(16'h0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bsg_locking_arb_burst_sink.md
# bsg_locking_arb_burst_sink

Downstream consumer for the locking fixed-priority arbiter.

- Takes the muxed beat stream of the currently granted requester and drives the arbiter's `ready_i`.
- Parses a length header on the first beat of each burst and counts the body beats.
- Pulses `unlock_o` on the final beat so the arbiter releases its lock.
- Buffers beats in a 2-entry queue that feeds a valid/yumi output tagged with the source index.

## Interface

Parameters:

- `inputs_p`, 16: number of arbiter requesters, which is also the width of `grants_i`.
- `width_p`, 32: data beat width.
- `len_width_p`, 8: width of the length field, located at header bits `[len_width_p-1:0]`. The value is the number of body beats that follow the header.

Ports:

- `clk_i`, input, 1: the single clock.
- `reset_n_i`, input, 1: reset, **asynchronous, active-low**.
- `grants_i`, input, `inputs_p`: one-hot grant vector from the arbiter. Any bit set means one beat is transferred this cycle.
- `data_i`, input, `width_p`: beat from the granted requester, muxed externally by `grants_i`.
- `ready_o`, output, 1: to the arbiter's `ready_i`. High when the buffer can accept a beat.
- `unlock_o`, output, 1: to the arbiter's `unlock_i`. Marks end of burst.
- `v_o`, output, 1: the head buffer entry is valid.
- `data_o`, output, `width_p`: head beat.
- `src_o`, output, `$clog2(inputs_p)`: requester index for the head beat.
- `last_o`, output, 1: the head beat ends its burst.
- `yumi_i`, input, 1: the consumer takes the head beat. Legal only while `v_o` is high.
- `error_o`, output, 1: sticky protocol error flag.

## Operation

- **Accept:** `acc = |grants_i`. Every accepted beat, header included, is written to the buffer with its source index and last flag.
- **FSM states:**
  - `HDR`, the reset state. On `acc`, capture `src = encode(grants_i)` and `len = data_i[len_width_p-1:0]`.
    - If `len==0`, the header is also the last beat: assert `unlock_o` and stay in `HDR`.
    - Otherwise load `cnt=len` and go to `BODY`.
  - `BODY`. On `acc`, decrement `cnt`.
    - When `cnt==1` on accept, that beat is last: assert `unlock_o` and go to `HDR`.
- **unlock_o:** `unlock_o = acc & last`, combinational in the same cycle as the accept. The arbiter mask clears at the following edge, so a new burst may be granted the very next cycle.
- **ready_o:** `ready_o = (count<2)`, derived from registered occupancy only, with no path from `yumi_i`.
- **Simultaneous events:** a write and a `yumi_i` in the same cycle on a full buffer are not possible, because `ready_o=0` means no grant.
  - Simultaneous write and pop at `count==1` keeps `count==1`.
- **Errors:** `error_o` sets on any of:
  - `acc` with a non-one-hot `grants_i`;
  - `acc` in `BODY` from a source different from the captured `src`;
  - `yumi_i` while `v_o==0`.
- **After an error:** the beat is still buffered, with `src_o` of the offending encode. `error_o` clears only on reset.
- **Counter width:** `cnt` is `len_width_p` bits. The maximum burst is `2^len_width_p - 1` body beats plus the header.
- **Reset (`reset_n_i` low):**
  - Clears the FSM to `HDR`, `cnt`, buffer occupancy and `error_o`.
  - Forces `ready_o=0` and `unlock_o=1` combinationally, so a lock held by the arbiter is released even on a reset mid-burst.
  - A partially buffered burst is discarded.

## Timing

- **Reset values:** `v_o=0`, `ready_o=0` (during reset), `unlock_o=1` (during reset), `error_o=0`, `data_o`/`src_o`/`last_o` don't-care.
- **After reset release:** `ready_o=1` in the first cycle.
- **Latency:** an accepted beat appears on `v_o` at the next edge (1 cycle). `unlock_o` has zero latency relative to the last accept.
- **Throughput:** one beat per cycle sustained while `yumi_i` is held high.
- **No combinational paths:** `grants_i` to `ready_o`, and `yumi_i` to `ready_o`.

## Structure

- **Package `bsg_burst_sink_pkg`:** FSM state enum (`e_hdr`, `e_body`), and the header length field position as a function of `len_width_p`.
- **Sub-module `bsg_burst_sink_buf`:** 2-entry FIFO holding `{last, src, data}`. It provides `ready_o` (not full), `v_o` and `yumi_i` ports, with async active-low reset.
- **Top level:** FSM, counter, one-hot encoder/checker and error logic (about 200 lines total).

## Test plan

- **Single burst:** header `len=3` from grant `0x0004`, then 3 beats with no stalls and `yumi_i` high.
  - `v_o` is seen 1 cycle later for each beat, with `src_o=2`.
  - `unlock_o` pulses exactly on the 4th accept, and `last_o=1` on the 4th output.
- **Zero-length burst:** header `len=0` from grant `0x8000`.
  - `unlock_o=1` in the same cycle, the FSM stays in `HDR`, and the output beat has `src_o=15` and `last_o=1`.
- **Backpressure:** `yumi_i=0` with 2 beats accepted.
  - `ready_o=0`, and no further accepts occur.
  - After `yumi_i=1` for one cycle, `ready_o=1` again and the data order is preserved.
- **Back-to-back bursts:** `len=1` from src 3, then a header from src 5 on the cycle immediately after the unlock.
  - Both bursts are delivered with the correct `src_o`, and `error_o` stays 0.
- **Protocol error:** a mid-burst grant switches to a different index, or `grants_i=0x0003` is applied.
  - `error_o` goes high the next cycle and stays high.
- **Reset mid-burst:** `reset_n_i` is pulsed low after 2 of 5 body beats.
  - `unlock_o=1` and `ready_o=0` during reset. After release: `v_o=0`, the FSM is in `HDR`, and the next beat is parsed as a header.
